control_sequencer: RTL and testbench

- Hardwired control unit that sits directly upstream of the datapath and drives all of its control inputs.
- It replaces the hand-written per-state stimulus with a real FSM: fetch (T0–T2), then decode and execute (T3–T5) for three-register ALU instructions.
- It decodes the IR value fed back from the datapath into one-hot register select/enable vectors and an ALU select code.
- It supports a memory-ready wait state, a halt request, and illegal-opcode trapping.

---
 rtl/cpu_ctrl_pkg.sv | 69 ++++++
 rtl/reg_select_decoder.sv | 35 +++
 rtl/control_sequencer.sv | 145 ++++++++++++++
 tb/tb_control_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// IR field positions, opcodes, ALU select codes and the opcode->ALU lookup.
package cpu_ctrl_pkg;

    localparam int OPC_W     = 5;
    localparam int ALU_SEL_W = 5;
    localparam int FIELD_W   = 4;

    // IR field bit positions
    localparam int IR_OPC_MSB = 31;
    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_MSB  = 26;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_MSB  = 22;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_MSB  = 18;
    localparam int IR_RC_LSB  = 15;

    // Sequencer phases: fetch is T0-T2, decode/execute is T3-T5
    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    // Opcodes of the three-register ALU instructions
    localparam logic [OPC_W-1:0] OPC_ADD = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_OR  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_SHR = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SHL = 5'b00110;

    // ALU operation select codes
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 5'b00011;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 5'b00100;
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 5'b01001;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 5'b01010;
    localparam logic [ALU_SEL_W-1:0] ALU_SHR = 5'b00101;
    localparam logic [ALU_SEL_W-1:0] ALU_SHL = 5'b00110;

    typedef struct packed {
        logic                 legal;
        logic [ALU_SEL_W-1:0] sel;
    } alu_dec_t;

    // Opcode -> ALU select; anything outside the table is flagged illegal
    function automatic alu_dec_t alu_lookup(input logic [OPC_W-1:0] opc);
        alu_dec_t r;
        r.legal = 1'b1;
        r.sel   = '0;
        case (opc)
            OPC_ADD: r.sel = ALU_ADD;
            OPC_SUB: r.sel = ALU_SUB;
            OPC_AND: r.sel = ALU_AND;
            OPC_OR:  r.sel = ALU_OR;
            OPC_SHR: r.sel = ALU_SHR;
            OPC_SHL: r.sel = ALU_SHL;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns the IR register fields plus the current phase into one-hot
// general-register bus-out (Rout) and load-enable (Rin) vectors.
module reg_select_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [FIELD_W-1:0]  ra_i,
    input  logic [FIELD_W-1:0]  rb_i,
    input  logic [FIELD_W-1:0]  rc_i,
    input  state_t              state_i,
    output logic [NUM_REGS-1:0] rin_o,
    output logic [NUM_REGS-1:0] rout_o
);

    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

    // Field value k selects bit k; values past NUM_REGS-1 shift out to zero
    function automatic logic [NUM_REGS-1:0] one_hot(input logic [FIELD_W-1:0] f);
        return ONE << f;
    endfunction

    // Rb is read in T3, Rc in T4, Ra written back in T5 (after both reads)
    always_comb begin
        rin_o  = '0;
        rout_o = '0;
        case (state_i)
            ST_T3:   rout_o = one_hot(rb_i);
            ST_T4:   rout_o = one_hot(rc_i);
            ST_T5:   rin_o  = one_hot(ra_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then decode/execute (T3-T5) of
// three-register ALU instructions, with memory wait, halt and illegal trap.
// MemReady is a level qualifier sampled only in T1: the sequencer holds the
// read strobe until it sees MemReady=1 on a rising edge; there is no
// acknowledge back to memory.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic [31:0]          IR,
    input  logic                 MemReady,
    input  logic                 Stop,
    output logic                 PCout,
    output logic                 Zlowout,
    output logic                 MDRout,
    output logic                 MARin,
    output logic                 PCin,
    output logic                 MDRin,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zin,
    output logic                 IncPC,
    output logic                 Read,
    output logic [NUM_REGS-1:0]  Rout,
    output logic [NUM_REGS-1:0]  Rin,
    output logic [ALU_SEL_W-1:0] ALUsel,
    output logic                 Run,
    output logic                 Illegal,
    output state_t               StateDbg
);

    state_t   state_q, state_d;
    logic     illegal_q, illegal_d;
    alu_dec_t alu_dec;

    logic [OPC_W-1:0]   opc;
    logic [FIELD_W-1:0] ra, rb, rc;
    logic               unused_ir;

    assign opc       = IR[IR_OPC_MSB:IR_OPC_LSB];
    assign ra        = IR[IR_RA_MSB:IR_RA_LSB];
    assign rb        = IR[IR_RB_MSB:IR_RB_LSB];
    assign rc        = IR[IR_RC_MSB:IR_RC_LSB];
    assign unused_ir = ^IR[IR_RC_LSB-1:0];
    assign alu_dec   = alu_lookup(opc);
    assign StateDbg  = state_q;
    assign Illegal   = illegal_q;

    // State and sticky illegal flag; Clear aborts any instruction at once
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q   <= ST_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic and Moore control outputs from the registered phase
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        ALUsel    = '0;
        Run       = 1'b1;
        case (state_q)
            ST_RST: begin
                Run     = 1'b0;
                state_d = ST_T0;
            end
            ST_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                // Re-loading PC from Z while waiting is idempotent
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (MemReady) state_d = ST_T2;
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                // Loading Y is harmless even when the opcode traps
                Yin = 1'b1;
                if (!alu_dec.legal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_T4;
                end
            end
            ST_T4: begin
                ALUsel  = alu_dec.sel;
                Zin     = 1'b1;
                state_d = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                state_d = Stop ? ST_HALT : ST_T0;
            end
            ST_HALT: begin
                Run = 1'b0;
            end
            default: begin
                Run     = 1'b0;
                state_d = ST_RST;
            end
        endcase
    end

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_select_decoder (
        .ra_i    (ra),
        .rb_i    (rb),
        .rc_i    (rc),
        .state_i (state_q),
        .rin_o   (Rin),
        .rout_o  (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected control words generated
// from the instruction-level phase rules, applied from a vector queue.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        Clock    = 1'b0;
    logic        Clear    = 1'b1;
    logic [31:0] IR       = '0;
    logic        MemReady = 1'b1;
    logic        Stop     = 1'b0;

    logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read;
    logic [15:0] Rout, Rin;
    logic [4:0]  ALUsel;
    logic        Run, Illegal;
    state_t      StateDbg;

    always #5 Clock = ~Clock;

    control_sequencer #(.NUM_REGS(16)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin), .ALUsel(ALUsel),
        .Run(Run), .Illegal(Illegal), .StateDbg(StateDbg)
    );

    // ---------------- control word and vector records ----------------
    typedef struct packed {
        logic pc_out, zlow_out, mdr_out, mar_in, pc_in, mdr_in, ir_in, y_in, z_in, inc_pc, read;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  alu_sel;
        logic run;
        logic illegal;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        logic        mem_ready;
        logic        stop;
        ctl_t        exp;
        string       name;
    } vec_t;

    ctl_t act;
    assign act = {PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
                  Rout, Rin, ALUsel, Run, Illegal};

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- scoreboard ----------------
    task automatic check(input ctl_t e, input string nm);
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s @%0t: got %h required %h (state %0d)", nm, $time, act, e, StateDbg);
    endtask

    // ---------------- reference model ----------------
    // ALU instruction table: opcode -> select, or -1 when not an ALU opcode
    function automatic int ref_alu(input logic [4:0] opc);
        case (opc)
            5'd3:  return 3;   // ADD
            5'd4:  return 4;   // SUB
            5'd8:  return 9;   // AND
            5'd9:  return 10;  // OR
            5'd5:  return 5;   // SHR
            5'd6:  return 6;   // SHL
            default: return -1;
        endcase
    endfunction

    function automatic ctl_t running();
        ctl_t e = '0;
        e.run = 1'b1;
        return e;
    endfunction

    function automatic logic rbit(input bit noise, input logic dflt);
        return noise ? logic'($urandom_range(0, 1)) : dflt;
    endfunction

    task automatic push(input logic [31:0] ir, input logic mr, input logic st,
                        input ctl_t e, input string nm);
        vec_t v;
        v.ir = ir; v.mem_ready = mr; v.stop = st; v.exp = e; v.name = nm;
        vq.push_back(v);
    endtask

    // Expected cycle sequence of one instruction: T0, (nwait+1) x T1, T2, T3,
    // then T4/T5 for legal opcodes or HALT with the trap flag otherwise.
    task automatic push_instr(input logic [31:0] ir, input int nwait,
                              input bit stop_t2, input bit stop_t5, input bit noise);
        ctl_t        e;
        logic [15:0] one = 16'h0001;
        int          sel = ref_alu(ir[31:27]);

        e = running(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
        push(ir, rbit(noise, 1'b1), rbit(noise, 1'b0), e, "T0_fetch");
        for (int i = 0; i <= nwait; i++) begin
            e = running(); e.zlow_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1;
            push(ir, logic'(i == nwait), rbit(noise, 1'b0), e, "T1_read");
        end
        e = running(); e.mdr_out = 1; e.ir_in = 1;
        push(ir, rbit(noise, 1'b1), logic'(stop_t2) | rbit(noise, 1'b0), e, "T2_ir_load");
        e = running(); e.rout = one << ir[22:19]; e.y_in = 1;
        push(ir, rbit(noise, 1'b1), rbit(noise, 1'b0), e, "T3_decode");
        if (sel < 0) begin
            for (int i = 0; i < 10; i++) begin
                e = '0; e.illegal = 1;
                push(ir, rbit(1, 1'b0), rbit(1, 1'b0), e, "HALT_illegal");
            end
            return;
        end
        e = running(); e.rout = one << ir[18:15]; e.alu_sel = 5'(sel); e.z_in = 1;
        push(ir, rbit(noise, 1'b1), rbit(noise, 1'b0), e, "T4_alu");
        e = running(); e.zlow_out = 1; e.rin = one << ir[26:23];
        push(ir, rbit(noise, 1'b1), logic'(stop_t5), e, "T5_writeback");
        if (stop_t5) begin
            for (int i = 0; i < 3; i++) begin
                e = '0;
                push(ir, rbit(1, 1'b0), rbit(1, 1'b0), e, "HALT_stop");
            end
        end
    endtask

    // ---------------- drivers ----------------
    // Compare at the falling edge, then drive that cycle's inputs
    task automatic apply_vecs(input int n);
        vec_t v;
        for (int i = 0; i < n && vq.size() > 0; i++) begin
            v = vq.pop_front();
            @(negedge Clock);
            check(v.exp, v.name);
            IR       = v.ir;
            MemReady = v.mem_ready;
            Stop     = v.stop;
        end
    endtask

    // Assert Clear immediately (asynchronously), hold, release at a falling edge
    task automatic do_reset(input int cycles);
        ctl_t z = '0;
        Clear = 1'b0;
        Stop  = 1'b0;
        #1;
        check(z, "reset_async");
        repeat (cycles) begin
            @(negedge Clock);
            check(z, "reset_hold");
        end
        Clear = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    logic [4:0] legal_opc [6] = '{5'b00011, 5'b00100, 5'b01000, 5'b01001, 5'b00101, 5'b00110};

    initial begin
        logic [31:0] ir;

        #2;
        do_reset(2);

        // OR R5,R2,R4 twice back to back, ADD, then a 3-cycle memory wait
        push_instr(32'h4A920000, 0, 0, 0, 0);
        push_instr(32'h4A920000, 0, 0, 0, 0);
        push_instr(32'h1A920000, 0, 0, 0, 0);
        push_instr(32'h21B38000, 3, 0, 0, 0);
        apply_vecs(vq.size());

        // Reset in the middle of T4, Clear low for 3 cycles
        push_instr(32'h4A920000, 0, 0, 0, 0);
        apply_vecs(5);
        vq.delete();
        do_reset(3);

        // Stop during T2 is ignored; Stop during T5 halts
        push_instr(32'h1A920000, 0, 1, 0, 0);
        push_instr(32'h1A920000, 0, 0, 1, 0);
        apply_vecs(vq.size());
        do_reset(1);

        // Random legal instructions, random waits and irrelevant input noise
        for (int k = 0; k < 25; k++) begin
            ir = $urandom();
            ir[31:27] = legal_opc[$urandom_range(0, 5)];
            push_instr(ir, int'($urandom_range(0, 3)), 0, (k == 24), 1);
        end
        apply_vecs(vq.size());
        do_reset(1);

        // Illegal opcode traps after T3 and stays halted
        ir = $urandom();
        ir[31:27] = 5'b11111;
        push_instr(ir, 1, 0, 0, 0);
        apply_vecs(vq.size());
        do_reset(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
